// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-addressed data RAM.
// Splits dwords into two word beats, extends loads, flags bad accesses.
module load_store_unit #(
   parameter int MEM_BYTES = 256,
   parameter int RAM_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [63:0] resp_rdata,
   output logic        ram_enable,
   output logic        ram_rw,
   output logic [31:0] ram_addr,
   output logic [1:0]  ram_mode,
   output logic [31:0] ram_datain,
   input  logic [31:0] ram_dataout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_lo_q, wdata_lo_d;
   logic        beat_q, beat_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] beat0_q, beat0_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [63:0] rdata_q, rdata_d;
   logic        ram_enable_q, ram_enable_d;
   logic        ram_rw_q, ram_rw_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [1:0]  ram_mode_q, ram_mode_d;
   logic [31:0] ram_datain_q, ram_datain_d;

   logic        accept;
   logic        misalign;
   logic        out_of_range;

   function automatic logic [63:0] ext_load(input logic [1:0]  sz,
                                            input logic        sg,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
      logic [63:0] r;
      unique case (sz)
         2'b00:   r = {{56{sg & lo[7]}}, lo[7:0]};
         2'b01:   r = {{48{sg & lo[15]}}, lo[15:0]};
         2'b10:   r = {{32{sg & lo[31]}}, lo};
         default: r = {hi, lo};
      endcase
      return r;
   endfunction

   assign accept = req_valid && req_ready_q;

   // Alignment and range check of the incoming request
   always_comb begin
      misalign = 1'b0;
      unique case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = |req_addr[2:0];
      endcase
      out_of_range = ({1'b0, req_addr} + (33'd1 << req_size))
                     > 33'(MEM_BYTES);
   end

   // Next-state and registered-output logic of the beat sequencer
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_d       = addr_q;
      wdata_lo_d   = wdata_lo_q;
      beat_d       = beat_q;
      cnt_d        = cnt_q;
      beat0_d      = beat0_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      rdata_d      = rdata_q;
      ram_enable_d = 1'b0;
      ram_rw_d     = ram_rw_q;
      ram_addr_d   = ram_addr_q;
      ram_mode_d   = ram_mode_q;
      ram_datain_d = ram_datain_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               write_d    = req_write;
               size_d     = req_size;
               signed_d   = req_signed;
               addr_d     = req_addr;
               wdata_lo_d = req_wdata[31:0];
               beat_d     = 1'b0;
               if (misalign || out_of_range) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  rdata_d      = 64'd0;
               end else begin
                  state_d      = ISSUE;
                  ram_enable_d = 1'b1;
                  ram_rw_d     = req_write;
                  ram_addr_d   = req_addr;
                  ram_mode_d   = (req_size == 2'b11) ? 2'b10 : req_size;
                  ram_datain_d = (req_size == 2'b11) ? req_wdata[63:32]
                                                     : req_wdata[31:0];
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = 3'(RAM_LAT);
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               if (size_q == 2'b11 && !beat_q) begin
                  beat0_d      = ram_dataout;
                  beat_d       = 1'b1;
                  state_d      = ISSUE;
                  ram_enable_d = 1'b1;
                  ram_addr_d   = addr_q + 32'd4;
                  ram_datain_d = wdata_lo_q;
               end else begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  rdata_d      = write_q ? 64'd0
                                         : ext_load(size_q, signed_q,
                                                    ram_dataout, beat0_q);
               end
            end
         end
         RESP: begin
            state_d    = IDLE;
            resp_err_d = 1'b0;
            rdata_d    = 64'd0;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         addr_q       <= 32'd0;
         wdata_lo_q   <= 32'd0;
         beat_q       <= 1'b0;
         cnt_q        <= 3'd0;
         beat0_q      <= 32'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= 64'd0;
         ram_enable_q <= 1'b0;
         ram_rw_q     <= 1'b0;
         ram_addr_q   <= 32'd0;
         ram_mode_q   <= 2'b00;
         ram_datain_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         addr_q       <= addr_d;
         wdata_lo_q   <= wdata_lo_d;
         beat_q       <= beat_d;
         cnt_q        <= cnt_d;
         beat0_q      <= beat0_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         rdata_q      <= rdata_d;
         ram_enable_q <= ram_enable_d;
         ram_rw_q     <= ram_rw_d;
         ram_addr_q   <= ram_addr_d;
         ram_mode_q   <= ram_mode_d;
         ram_datain_q <= ram_datain_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign ram_enable = ram_enable_q;
   assign ram_rw     = ram_rw_q;
   assign ram_addr   = ram_addr_q;
   assign ram_mode   = ram_mode_q;
   assign ram_datain = ram_datain_q;

endmodule
